// File: rtl/shift_seq_ctrl_if.sv
// shift_seq_ctrl_if: control/data bundle between a sequence requester, the controller and an external 31-bit shift register
// Ports (slave = controller side):
//   in : start, seed[30:0], nbits[5:0], mode, ext_serial_in, shift_q[30:0]
//   out: shift_set, shift_preset[30:0], shift_serial_in, busy, done, data_out[31:0]
interface shift_seq_ctrl_if;
   logic        start;
   logic [30:0] seed;
   logic [5:0]  nbits;
   logic        mode;
   logic        ext_serial_in;
   logic [30:0] shift_q;
   logic        shift_set;
   logic [30:0] shift_preset;
   logic        shift_serial_in;
   logic        busy;
   logic        done;
   logic [31:0] data_out;
   modport slave (
      input  start, seed, nbits, mode, ext_serial_in, shift_q,
      output shift_set, shift_preset, shift_serial_in, busy, done, data_out
   );
   modport master (
      output start, seed, nbits, mode, ext_serial_in, shift_q,
      input  shift_set, shift_preset, shift_serial_in, busy, done, data_out
   );
endinterface

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences one load-then-shift run of an external 31-bit shift register and captures its LSB stream
// Ports:
//   qzt_clk : system clock, rising edge
//   reset   : synchronous active-high reset
//   bus     : shift_seq_ctrl_if.slave (request, shift register control/feedback, status, captured data)
module shift_seq_ctrl (
   input logic             qzt_clk,
   input logic             reset,
   shift_seq_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
   state_t      r_state;
   logic [30:0] r_seed;
   logic [5:0]  r_n;
   logic        r_mode;
   logic [4:0]  r_count;
   logic [31:0] r_data;
   logic [5:0]  w_n;
   // 0 and anything above 32 both mean a full 32-bit run
   assign w_n = (bus.nbits == 6'd0 || bus.nbits > 6'd32) ? 6'd32 : bus.nbits;
   always_ff @(posedge qzt_clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_seed  <= '0;
         r_n     <= 6'd32;
         r_mode  <= 1'b0;
         r_count <= '0;
         r_data  <= '0;
      end else begin
         case (r_state)
            IDLE: if (bus.start) begin
               r_seed  <= bus.seed;
               r_n     <= w_n;
               r_mode  <= bus.mode;
               r_state <= LOAD;
            end
            LOAD: begin
               r_count <= '0;
               r_data  <= '0;
               r_state <= SHIFT;
            end
            SHIFT: begin
               r_data[r_count] <= bus.shift_q[0];
               r_count         <= r_count + 5'd1;
               if ({1'b0, r_count} == r_n - 6'd1) r_state <= DONE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   // reset overrides the state decode so the external register is cleared on the same edge
   assign bus.busy            = !reset && r_state != IDLE;
   assign bus.done            = !reset && r_state == DONE;
   assign bus.shift_set       = reset || r_state != SHIFT;
   assign bus.shift_preset    = reset ? 31'd0 : (r_state == LOAD ? r_seed : bus.shift_q);
   // PRBS31 (x^31 + x^28 + 1) in the right-shifting orientation
   assign bus.shift_serial_in = r_mode ? bus.shift_q[0] ^ bus.shift_q[3] : bus.ext_serial_in;
   assign bus.data_out        = r_data;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: table-driven, directed and randomized checks of shift_seq_ctrl against a bit-stream model
module tb_shift_seq_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [30:0] sq;
   int          vecs = 0;
   int          errs = 0;
   typedef struct {
      logic [30:0] sd;
      logic [5:0]  nb;
      logic        md;
      logic [31:0] ev;
      logic [31:0] exp_d;
      int          exp_lat;
   } vec_t;
   vec_t tbl [5];
   shift_seq_ctrl_if s ();
   shift_seq_ctrl dut (.qzt_clk(clk), .reset(reset), .bus(s));
   always #5 clk = ~clk;
   // the external shift register the controller drives
   assign s.shift_q = sq;
   always @(posedge clk) sq <= s.shift_set ? s.shift_preset : {s.shift_serial_in, sq[30:1]};
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask
   // stream b[k]: seed bits first, then each inserted bit; captured bit i is b[i], final register bit j is b[n+j]
   function automatic void model(input logic [30:0] sd, input logic [5:0] nb, input logic md,
                                 input logic [31:0] ev, output logic [31:0] d, output logic [30:0] q);
      int   n;
      logic b [0:62];
      n = (nb == 6'd0 || nb > 6'd32) ? 32 : int'(nb);
      for (int k = 0; k < 63; k++)
         b[k] = k < 31 ? sd[k] : (md ? b[k-31] ^ b[k-28] : ev[k-31]);
      d = '0;
      for (int i = 0; i < n; i++) d[i] = b[i];
      for (int j = 0; j < 31; j++) q[j] = b[n+j];
   endfunction
   // call #1 after an edge with the DUT idle; start is presented in cycle 0, k counts edges after that
   task automatic run_chk(input string nm, input logic [30:0] sd, input logic [5:0] nb, input logic md,
                          input logic [31:0] ev, input int sk1, input int sk2, input int rk, input int exp_lat,
                          output logic [31:0] got_d);
      int          lat;
      int          nd;
      logic [31:0] md_d;
      logic [30:0] md_q;
      lat = -1;
      nd  = 0;
      s.start = 1'b1;
      s.seed  = sd;
      s.nbits = nb;
      s.mode  = md;
      s.ext_serial_in = 1'($urandom);
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         reset = (k == rk);
         if (k == rk + 1) begin
            chk({nm, "_rst_busy"}, s.busy, 0);
            chk({nm, "_rst_data"}, s.data_out, 0);
            chk({nm, "_rst_q"}, sq, 0);
         end
         if (k == sk2 + 1) chk({nm, "_ign_busy"}, s.busy, 0);
         if (k == 1) chk({nm, "_busy"}, s.busy, 1);
         if (s.done) begin
            nd++;
            if (lat < 0) lat = k;
         end
         s.start = (k == sk1 || k == sk2);
         s.seed  = 31'($urandom);
         s.nbits = 6'($urandom);
         s.mode  = 1'($urandom);
         s.ext_serial_in = (k >= 2 && k <= 33) ? ev[k-2] : 1'($urandom);
      end
      got_d = s.data_out;
      chk({nm, "_ndone"}, nd, rk < 0 ? 1 : 0);
      if (rk < 0) begin
         model(sd, nb, md, ev, md_d, md_q);
         chk({nm, "_lat"}, lat, exp_lat);
         chk({nm, "_data"}, s.data_out, md_d);
         chk({nm, "_q"}, sq, {1'b0, md_q});
      end
   endtask
   initial begin
      logic [31:0] d;
      logic [30:0] q0;
      logic [5:0]  nb;
      tbl[0] = '{31'h1,        6'd4,  1'b0, 32'h0,        32'h00000001, 6};
      tbl[1] = '{31'h7FFFFFFF, 6'd0,  1'b1, 32'h0,        32'h7FFFFFFF, 34};
      tbl[2] = '{31'h0,        6'd32, 1'b0, 32'hFFFFFFFF, 32'h80000000, 34};
      tbl[3] = '{31'h5,        6'd3,  1'b0, 32'h0,        32'h00000005, 5};
      tbl[4] = '{31'h2AAAAAAA, 6'd45, 1'b0, 32'h0,        32'h2AAAAAAA, 34};
      s.start = 1'b0;
      s.seed  = '0;
      s.nbits = '0;
      s.mode  = 1'b0;
      s.ext_serial_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", s.busy, 0);
      chk("rst_done", s.done, 0);
      chk("rst_set", s.shift_set, 1);
      chk("rst_preset", s.shift_preset, 0);
      chk("rst_data", s.data_out, 0);
      chk("rst_q", sq, 0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 3) begin
            run_chk("ignore", 31'h9, 6'd8, 1'b0, 32'h0, 4, 10, -1, 10, d);
            chk("ignore_const", d, 32'h00000009);
         end
         run_chk($sformatf("tbl%0d", i), tbl[i].sd, tbl[i].nb, tbl[i].md, tbl[i].ev, -1, -1, -1, tbl[i].exp_lat, d);
         chk($sformatf("tbl%0d_const", i), d, tbl[i].exp_d);
      end
      q0 = sq;
      repeat (100) @(posedge clk);
      #1;
      chk("idle_hold_q", sq, q0);
      chk("idle_busy", s.busy, 0);
      run_chk("abort", 31'h1234567, 6'd10, 1'b0, 32'h3FF, -1, -1, 4, 0, d);
      for (int r = 0; r < 30; r++) begin
         nb = 6'($urandom_range(0, 63));
         run_chk($sformatf("rnd%0d", r), 31'($urandom), nb, 1'($urandom), $urandom, -1, -1, -1,
                 (nb == 6'd0 || nb > 6'd32) ? 34 : int'(nb) + 2, d);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
